// File: rtl/alu_pkg.sv
// Shared ALU opcode and control-state definitions.
// Imported by seq_alu and its iterative datapath.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  localparam int unsigned UNDEF_LO = 14;
  localparam int unsigned UNDEF_HI = 15;

endpackage

// File: rtl/alu_iter.sv
// Bit-serial engine: shift-add multiply or restoring divide.
// hi/lo share storage: product hi/lo, or remainder/quotient.
module alu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  div_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          busy_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  m_q;
  logic [W:0]    sum;
  logic [W:0]    rr;
  logic [W:0]    diff;
  logic          ge;

  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, lo_q[0] ? m_q : '0};
    rr   = {hi_q, lo_q[W-1]};
    diff = rr - {1'b0, m_q};
    ge   = !diff[W];
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_q) begin
      // A zero divisor always subtracts: quotient all ones, rem = dividend.
      hi_d = ge ? diff[W-1:0] : rr[W-1:0];
      lo_d = {lo_q[W-2:0], ge};
    end else begin
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a_i;
      m_q    <= b_i;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: 1-cycle logic ops, DATA_WIDTH-cycle mul/div.
// Results are held until the consumer takes them.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [CTRL_WIDTH-1:0] ALUctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  err
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int C  = CTRL_WIDTH;

  localparam logic [C-1:0] C_ADD   = C'(OP_ADD);
  localparam logic [C-1:0] C_SUB   = C'(OP_SUB);
  localparam logic [C-1:0] C_AND   = C'(OP_AND);
  localparam logic [C-1:0] C_OR    = C'(OP_OR);
  localparam logic [C-1:0] C_XOR   = C'(OP_XOR);
  localparam logic [C-1:0] C_SLT   = C'(OP_SLT);
  localparam logic [C-1:0] C_SLTU  = C'(OP_SLTU);
  localparam logic [C-1:0] C_SLL   = C'(OP_SLL);
  localparam logic [C-1:0] C_SRL   = C'(OP_SRL);
  localparam logic [C-1:0] C_SRA   = C'(OP_SRA);
  localparam logic [C-1:0] C_MUL   = C'(OP_MUL);
  localparam logic [C-1:0] C_MULHU = C'(OP_MULHU);
  localparam logic [C-1:0] C_DIVU  = C'(OP_DIVU);
  localparam logic [C-1:0] C_REMU  = C'(OP_REMU);
  localparam logic [C-1:0] C_UNDEF = C'(UNDEF_LO);

  state_e        state_q;
  logic          out_valid_q;
  logic [W-1:0]  out_q;
  logic          eq_q;
  logic          err_q;
  logic          eq_pend_q;
  logic          hi_sel_q;

  logic [W-1:0]  res;
  logic [SW-1:0] shamt;
  logic          eq_now;
  logic          is_mul, is_div, hi_sel, undef;
  logic          accept, start;
  logic          it_done;
  logic [W-1:0]  it_hi, it_lo;

  assign shamt  = ALUop2[SW-1:0];
  assign eq_now = (ALUop1 == ALUop2);
  assign is_mul = (ALUctrl == C_MUL) || (ALUctrl == C_MULHU);
  assign is_div = (ALUctrl == C_DIVU) || (ALUctrl == C_REMU);
  assign hi_sel = (ALUctrl == C_MULHU) || (ALUctrl == C_REMU);
  assign undef  = (ALUctrl >= C_UNDEF);

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && (is_mul || is_div);

  always_comb begin
    res = '0;
    case (ALUctrl)
      C_ADD:  res = ALUop1 + ALUop2;
      C_SUB:  res = ALUop1 - ALUop2;
      C_AND:  res = ALUop1 & ALUop2;
      C_OR:   res = ALUop1 | ALUop2;
      C_XOR:  res = ALUop1 ^ ALUop2;
      C_SLT:  res = {{(W-1){1'b0}},
                     $signed(ALUop1) < $signed(ALUop2)};
      C_SLTU: res = {{(W-1){1'b0}}, ALUop1 < ALUop2};
      C_SLL:  res = ALUop1 << shamt;
      C_SRL:  res = ALUop1 >> shamt;
      C_SRA:  res = W'($signed(ALUop1) >>> shamt);
      default: res = '0;
    endcase
  end

  alu_iter #(.DATA_WIDTH(W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .div_i  (is_div),
    .a_i    (ALUop1),
    .b_i    (ALUop2),
    .done_o (it_done),
    .hi_o   (it_hi),
    .lo_o   (it_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      eq_q        <= 1'b0;
      err_q       <= 1'b0;
      eq_pend_q   <= 1'b0;
      hi_sel_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // accept implies any held result is consumed on this edge
            state_q     <= is_mul ? MUL : DIV;
            out_valid_q <= 1'b0;
            eq_pend_q   <= eq_now;
            hi_sel_q    <= hi_sel;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= res;
            eq_q        <= eq_now;
            err_q       <= undef;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL, DIV: begin
          if (it_done) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            out_q       <= hi_sel_q ? it_hi : it_lo;
            eq_q        <= eq_pend_q;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign ALUout    = out_q;
  assign EQ        = eq_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes expectations,
// monitor pops on each output handshake.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  ALUop1;
  logic [W-1:0]  ALUop2;
  logic [3:0]    ALUctrl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ALUout;
  logic          EQ;
  logic          err;

  seq_alu #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUop1   (ALUop1),
    .ALUop2   (ALUop2),
    .ALUctrl  (ALUctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUout   (ALUout),
    .EQ       (EQ),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] data;
    logic         eq;
    logic         er;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Latency counts edges from the accept edge to the edge that
  // raises out_valid: 0 for 1-cycle ops, W for mul/div.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none",
                 ALUout);
      end else begin
        it = sb.pop_front();
        chk({it.tag, ".out"}, 64'(ALUout), 64'(it.data));
        chk({it.tag, ".eq"},  64'(EQ),     64'(it.eq));
        chk({it.tag, ".err"}, 64'(err),    64'(it.er));
        if (it.lat >= 0)
          chk({it.tag, ".lat"}, 64'(cyc - it.acc), 64'(it.lat));
      end
    end
  end

  task automatic issue(input string tag,
                       input logic [3:0] c,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] x,
                       input logic xe,
                       input logic xr,
                       input bit multi,
                       input bit lat_chk);
    int k;
    ALUctrl  = c;
    ALUop1   = a;
    ALUop2   = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.accept: got timeout expected in_ready",
               tag);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back('{tag, x, xe, xr,
                   lat_chk ? (multi ? W : 0) : -1, cyc});
    if (multi) begin
      // in_valid stays high here; a second accept would show up
      for (int i = 0; i < W - 1; i++) begin
        @(negedge clk);
        chk({tag, ".busy_rdy"}, 64'(in_ready), 64'd0);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(sb.size() == 0 && !out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
  endtask

  int hits;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUop1    = '0;
    ALUop2    = '0;
    ALUctrl   = '0;
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.out",   64'(ALUout),    64'd0);
    chk("rst.eq",    64'(EQ),        64'd0);
    chk("rst.err",   64'(err),       64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    issue("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1,
          32'h0, 1'b0, 1'b0, 0, 1);
    issue("sub_eq", 4'd1, 32'd5, 32'd5,
          32'h0, 1'b1, 1'b0, 0, 1);
    issue("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
          32'h00F0_00F0, 1'b0, 1'b0, 0, 1);
    issue("or", 4'd3, 32'h1234_0000, 32'h0000_5678,
          32'h1234_5678, 1'b0, 1'b0, 0, 1);
    issue("xor", 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F,
          32'hF0F0_0F0F, 1'b0, 1'b0, 0, 1);
    issue("slt", 4'd5, 32'hFFFF_FFFF, 32'd1,
          32'd1, 1'b0, 1'b0, 0, 1);
    issue("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1,
          32'd0, 1'b0, 1'b0, 0, 1);
    issue("sll31", 4'd7, 32'd1, 32'd31,
          32'h8000_0000, 1'b0, 1'b0, 0, 1);
    issue("sll_mask", 4'd7, 32'd1, 32'h21,
          32'd2, 1'b0, 1'b0, 0, 1);
    issue("srl", 4'd8, 32'h8000_0000, 32'd4,
          32'h0800_0000, 1'b0, 1'b0, 0, 1);
    issue("sra", 4'd9, 32'h8000_0000, 32'd4,
          32'hF800_0000, 1'b0, 1'b0, 0, 1);
    issue("undef14", 4'd14, 32'd3, 32'd3,
          32'd0, 1'b1, 1'b1, 0, 1);
    issue("undef15", 4'd15, 32'd1, 32'd2,
          32'd0, 1'b0, 1'b1, 0, 1);

    issue("mul", 4'd10, 32'h1_0000, 32'h1_0000,
          32'h0, 1'b1, 1'b0, 1, 1);
    issue("mulhu", 4'd11, 32'h1_0000, 32'h1_0000,
          32'h1, 1'b1, 1'b0, 1, 1);
    issue("mul7x6", 4'd10, 32'd7, 32'd6,
          32'd42, 1'b0, 1'b0, 1, 1);
    issue("mulhu_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
          32'hFFFF_FFFD, 1'b0, 1'b0, 1, 1);
    issue("divu", 4'd12, 32'd100, 32'd7,
          32'd14, 1'b0, 1'b0, 1, 1);
    issue("remu", 4'd13, 32'd100, 32'd7,
          32'd2, 1'b0, 1'b0, 1, 1);
    issue("divu0", 4'd12, 32'd9, 32'd0,
          32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1);
    issue("remu0", 4'd13, 32'd9, 32'd0,
          32'd9, 1'b0, 1'b0, 1, 1);

    issue("b2b0", 4'd0, 32'd1, 32'd2,
          32'd3, 1'b0, 1'b0, 0, 1);
    issue("b2b1", 4'd0, 32'd10, 32'd20,
          32'd30, 1'b0, 1'b0, 0, 1);
    issue("b2b2", 4'd0, 32'h7FFF_FFFF, 32'd1,
          32'h8000_0000, 1'b0, 1'b0, 0, 1);
    issue("b2b3", 4'd0, 32'd100, 32'd200,
          32'd300, 1'b0, 1'b0, 0, 1);
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    issue("hold", 4'd0, 32'h11, 32'h22,
          32'h33, 1'b0, 1'b0, 0, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold.valid", 64'(out_valid), 64'd1);
      chk("hold.out",   64'(ALUout),    64'h33);
      chk("hold.eq",    64'(EQ),        64'd0);
      chk("hold.err",   64'(err),       64'd0);
      chk("hold.rdy",   64'(in_ready),  64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    ALUctrl  = 4'd12;
    ALUop1   = 32'd100;
    ALUop2   = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("abort.no_result", 64'(hits), 64'd0);
    issue("post_rst_add", 4'd0, 32'd2, 32'd3,
          32'd5, 1'b0, 1'b0, 0, 1);
    in_valid = 1'b0;
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
